// File: rtl/audio_dac_pkg.sv
// Shared constants and parameter-legality helpers for the 4-bit ladder audio DAC.
package audio_dac_pkg;

    localparam int DAC_W = 4;
    localparam logic [DAC_W-1:0] SAT_CODE = 4'd15;

    localparam int WIN_LOG2_MIN = 4;
    localparam int WIN_LOG2_MAX = 10;
    localparam int GAIN_MIN     = 0;
    localparam int GAIN_MAX     = 3;

    function automatic bit win_log2_legal(input int w);
        return (w >= WIN_LOG2_MIN) && (w <= WIN_LOG2_MAX);
    endfunction

    function automatic bit gain_legal(input int g);
        return (g >= GAIN_MIN) && (g <= GAIN_MAX);
    endfunction

endpackage

// File: rtl/pwm_window_count.sv
// One audio channel: synchronizes the PWM bit, counts ones over the window and
// turns the window count into a gained, saturated 4-bit ladder code.
module pwm_window_count
    import audio_dac_pkg::*;
#(
    parameter int C_win_log2 = 6,
    parameter int C_gain     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_i,
    input  logic             win_end_i,
    output logic [DAC_W-1:0] code_o
);

    localparam int W  = C_win_log2;
    localparam int GW = W + 4;
    // 2^W: a gained count at or above this no longer fits the top ladder bits
    localparam logic [GW-1:0] FULL_SCALE = GW'(1) << W;

    logic          sync1_q;
    logic          sync2_q;
    logic [W:0]    acc_q;
    logic [W:0]    acc_d;
    logic [W:0]    cnt_s;
    logic [GW-1:0] gain_s;

    // Two-stage synchronizer for the asynchronous PWM input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
        end
    end

    // Window count includes the current sample; accumulator restarts at window end
    always_comb begin
        cnt_s = acc_q + {{W{1'b0}}, sync2_q};
        if (win_end_i) begin
            acc_d = {(W+1){1'b0}};
        end else begin
            acc_d = cnt_s;
        end
    end

    // Apply static gain and saturate to full-scale code
    always_comb begin
        gain_s = {3'b000, cnt_s} << C_gain;
        if (gain_s >= FULL_SCALE) begin
            code_o = SAT_CODE;
        end else begin
            code_o = gain_s[W-1:W-4];
        end
    end

    // Ones accumulator for the current window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {(W+1){1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/audio_pwm_dac4.sv
// Stereo PWM-to-4-bit-ladder audio back end: shared window phase, mute and
// sample strobe around two per-channel window counters.
module audio_pwm_dac4
    import audio_dac_pkg::*;
#(
    parameter int C_win_log2 = 6,
    parameter int C_gain     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_l,
    input  logic             in_r,
    input  logic             mute,
    output logic [DAC_W-1:0] out_l,
    output logic [DAC_W-1:0] out_r,
    output logic             sample_strobe
);

    localparam int W = C_win_log2;

    if (!win_log2_legal(C_win_log2)) begin : g_bad_win_log2
        $error("audio_pwm_dac4: C_win_log2 outside legal range");
    end
    if (!gain_legal(C_gain)) begin : g_bad_gain
        $error("audio_pwm_dac4: C_gain outside legal range");
    end

    logic [W-1:0]     phase_q;
    logic [W-1:0]     phase_d;
    logic             win_end_s;
    logic [DAC_W-1:0] code_l_s;
    logic [DAC_W-1:0] code_r_s;
    logic [DAC_W-1:0] out_l_q;
    logic [DAC_W-1:0] out_l_d;
    logic [DAC_W-1:0] out_r_q;
    logic [DAC_W-1:0] out_r_d;
    logic             strobe_q;

    pwm_window_count #(
        .C_win_log2 (C_win_log2),
        .C_gain     (C_gain)
    ) u_chan_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_i     (in_l),
        .win_end_i (win_end_s),
        .code_o    (code_l_s)
    );

    pwm_window_count #(
        .C_win_log2 (C_win_log2),
        .C_gain     (C_gain)
    ) u_chan_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_i     (in_r),
        .win_end_i (win_end_s),
        .code_o    (code_r_s)
    );

    // Free-running phase; the last phase of the window is the update slot
    always_comb begin
        phase_d   = phase_q + {{(W-1){1'b0}}, 1'b1};
        win_end_s = (phase_q == {W{1'b1}});
    end

    // Mute wins over a window-end load; otherwise hold the last code
    always_comb begin
        if (mute) begin
            out_l_d = {DAC_W{1'b0}};
            out_r_d = {DAC_W{1'b0}};
        end else if (win_end_s) begin
            out_l_d = code_l_s;
            out_r_d = code_r_s;
        end else begin
            out_l_d = out_l_q;
            out_r_d = out_r_q;
        end
    end

    // Phase, output codes and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= {W{1'b0}};
            out_l_q  <= {DAC_W{1'b0}};
            out_r_q  <= {DAC_W{1'b0}};
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
            strobe_q <= win_end_s;
        end
    end

    assign out_l         = out_l_q;
    assign out_r         = out_r_q;
    assign sample_strobe = strobe_q;

endmodule
